// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants for the ID stage: instruction groups, ALU ops, result selects,
// FSM encodings and the decoded-instruction bundle passed from id_dec to id_stage_pipe.
package id_stage_pipe_pkg;

    localparam logic [5:0] INS_OP_GRP_SPECIAL = 6'b000000;
    localparam logic [5:0] INS_OP_GRP_ANDI    = 6'b001100;
    localparam logic [5:0] INS_OP_GRP_ORI     = 6'b001101;
    localparam logic [5:0] INS_OP_GRP_XORI    = 6'b001110;
    localparam logic [5:0] INS_OP_GRP_LUI     = 6'b001111;

    localparam logic [5:0] INS_FUNC_GRP_SLL  = 6'b000000;
    localparam logic [5:0] INS_FUNC_GRP_SRL  = 6'b000010;
    localparam logic [5:0] INS_FUNC_GRP_SRA  = 6'b000011;
    localparam logic [5:0] INS_FUNC_GRP_SLLV = 6'b000100;
    localparam logic [5:0] INS_FUNC_GRP_SRLV = 6'b000110;
    localparam logic [5:0] INS_FUNC_GRP_SRAV = 6'b000111;
    localparam logic [5:0] INS_FUNC_GRP_MOVZ = 6'b001010;
    localparam logic [5:0] INS_FUNC_GRP_MOVN = 6'b001011;
    localparam logic [5:0] INS_FUNC_GRP_ADD  = 6'b100000;
    localparam logic [5:0] INS_FUNC_GRP_ADDU = 6'b100001;
    localparam logic [5:0] INS_FUNC_GRP_SUB  = 6'b100010;
    localparam logic [5:0] INS_FUNC_GRP_SUBU = 6'b100011;
    localparam logic [5:0] INS_FUNC_GRP_AND  = 6'b100100;
    localparam logic [5:0] INS_FUNC_GRP_OR   = 6'b100101;
    localparam logic [5:0] INS_FUNC_GRP_XOR  = 6'b100110;
    localparam logic [5:0] INS_FUNC_GRP_NOR  = 6'b100111;
    localparam logic [5:0] INS_FUNC_GRP_SLT  = 6'b101010;
    localparam logic [5:0] INS_FUNC_GRP_SLTU = 6'b101011;

    localparam logic [7:0] EXE_OP_NOP  = 8'b00000000;
    localparam logic [7:0] EXE_OP_AND  = 8'b00100100;
    localparam logic [7:0] EXE_OP_OR   = 8'b00100101;
    localparam logic [7:0] EXE_OP_XOR  = 8'b00100110;
    localparam logic [7:0] EXE_OP_NOR  = 8'b00100111;
    localparam logic [7:0] EXE_OP_SLL  = 8'b01111100;
    localparam logic [7:0] EXE_OP_SRL  = 8'b00000010;
    localparam logic [7:0] EXE_OP_SRA  = 8'b00000011;
    localparam logic [7:0] EXE_OP_MOVZ = 8'b00001010;
    localparam logic [7:0] EXE_OP_MOVN = 8'b00001011;
    localparam logic [7:0] EXE_OP_ADD  = 8'b00100000;
    localparam logic [7:0] EXE_OP_ADDU = 8'b00100001;
    localparam logic [7:0] EXE_OP_SUB  = 8'b00100010;
    localparam logic [7:0] EXE_OP_SUBU = 8'b00100011;
    localparam logic [7:0] EXE_OP_SLT  = 8'b00101010;
    localparam logic [7:0] EXE_OP_SLTU = 8'b00101011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HAZ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [7:0]  alu_op;
        logic [2:0]  alu_sel;
        logic        reg0_read;
        logic        reg1_read;
        logic        sft;
        logic        imme_up;
        logic [4:0]  waddr;
        logic        wreg_base;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [15:0] imm;
    } dec_t;

endpackage

// File: rtl/id_dec.sv
// Purpose: combinational instruction decode into the dec_t bundle.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; consumer decides when the result is used.
module id_dec
    import id_stage_pipe_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = inst[31:26];
    assign funct = inst[5:0];

    always_comb begin
        dec       = '0;
        dec.rs    = inst[25:21];
        dec.rt    = inst[20:16];
        dec.shamt = inst[10:6];
        dec.imm   = inst[15:0];
        case (op)
            INS_OP_GRP_SPECIAL: begin
                dec.waddr = inst[15:11];
                case (funct)
                    INS_FUNC_GRP_SLL, INS_FUNC_GRP_SRL, INS_FUNC_GRP_SRA: begin
                        // Immediate shifts read only rt; port 0 carries shamt instead.
                        if (inst[25:21] == 5'd0) begin
                            dec.reg1_read = 1'b1;
                            dec.sft       = 1'b1;
                            dec.alu_sel   = EXE_RES_SHIFT;
                            dec.wreg_base = 1'b1;
                            dec.alu_op    = (funct == INS_FUNC_GRP_SLL) ? EXE_OP_SLL :
                                            (funct == INS_FUNC_GRP_SRL) ? EXE_OP_SRL : EXE_OP_SRA;
                        end
                    end
                    default: begin
                        if (inst[10:6] == 5'd0) begin
                            dec.reg0_read = 1'b1;
                            dec.reg1_read = 1'b1;
                            dec.wreg_base = 1'b1;
                            case (funct)
                                INS_FUNC_GRP_AND:  begin dec.alu_op = EXE_OP_AND;  dec.alu_sel = EXE_RES_LOGIC; end
                                INS_FUNC_GRP_OR:   begin dec.alu_op = EXE_OP_OR;   dec.alu_sel = EXE_RES_LOGIC; end
                                INS_FUNC_GRP_XOR:  begin dec.alu_op = EXE_OP_XOR;  dec.alu_sel = EXE_RES_LOGIC; end
                                INS_FUNC_GRP_NOR:  begin dec.alu_op = EXE_OP_NOR;  dec.alu_sel = EXE_RES_LOGIC; end
                                INS_FUNC_GRP_SLLV: begin dec.alu_op = EXE_OP_SLL;  dec.alu_sel = EXE_RES_SHIFT; end
                                INS_FUNC_GRP_SRLV: begin dec.alu_op = EXE_OP_SRL;  dec.alu_sel = EXE_RES_SHIFT; end
                                INS_FUNC_GRP_SRAV: begin dec.alu_op = EXE_OP_SRA;  dec.alu_sel = EXE_RES_SHIFT; end
                                INS_FUNC_GRP_MOVZ: begin dec.alu_op = EXE_OP_MOVZ; dec.alu_sel = EXE_RES_MOVE;  end
                                INS_FUNC_GRP_MOVN: begin dec.alu_op = EXE_OP_MOVN; dec.alu_sel = EXE_RES_MOVE;  end
                                INS_FUNC_GRP_ADD:  begin dec.alu_op = EXE_OP_ADD;  dec.alu_sel = EXE_RES_ARITH; end
                                INS_FUNC_GRP_ADDU: begin dec.alu_op = EXE_OP_ADDU; dec.alu_sel = EXE_RES_ARITH; end
                                INS_FUNC_GRP_SUB:  begin dec.alu_op = EXE_OP_SUB;  dec.alu_sel = EXE_RES_ARITH; end
                                INS_FUNC_GRP_SUBU: begin dec.alu_op = EXE_OP_SUBU; dec.alu_sel = EXE_RES_ARITH; end
                                INS_FUNC_GRP_SLT:  begin dec.alu_op = EXE_OP_SLT;  dec.alu_sel = EXE_RES_ARITH; end
                                INS_FUNC_GRP_SLTU: begin dec.alu_op = EXE_OP_SLTU; dec.alu_sel = EXE_RES_ARITH; end
                                default: begin
                                    dec.reg0_read = 1'b0;
                                    dec.reg1_read = 1'b0;
                                    dec.wreg_base = 1'b0;
                                end
                            endcase
                        end
                    end
                endcase
            end
            INS_OP_GRP_ANDI, INS_OP_GRP_ORI, INS_OP_GRP_XORI, INS_OP_GRP_LUI: begin
                dec.reg0_read = 1'b1;
                dec.waddr     = inst[20:16];
                dec.wreg_base = 1'b1;
                dec.alu_sel   = EXE_RES_LOGIC;
                dec.imme_up   = (op == INS_OP_GRP_LUI);
                dec.alu_op    = (op == INS_OP_GRP_ANDI) ? EXE_OP_AND :
                                (op == INS_OP_GRP_XORI) ? EXE_OP_XOR : EXE_OP_OR;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Purpose: MIPS decode stage with regfile read, forwarding, load-use stall and ID/EX register.
// Latency: 1 cycle from accepted instruction to out_vld.
// Backpressure: holds ID/EX contents while !ex_rdy; drops in_rdy on hazard, hold or flush.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_FWD     = 2,
    parameter int ALU_OP_W    = 8,
    parameter int ALU_SEL_W   = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      in_vld,
    output logic                      in_rdy,
    input  logic [31:0]               in_pc,
    input  logic [31:0]               in_inst,
    input  logic                      flush,
    output logic                      reg0_read,
    output logic [4:0]                reg0_addr,
    input  logic [DATA_W-1:0]         reg0_data,
    output logic                      reg1_read,
    output logic [4:0]                reg1_addr,
    input  logic [DATA_W-1:0]         reg1_data,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [5*NUM_FWD-1:0]      fwd_waddr,
    input  logic [DATA_W*NUM_FWD-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    input  logic                      ex_rdy,
    output logic                      out_vld,
    output logic [31:0]               out_pc,
    output logic [ALU_OP_W-1:0]       out_alu_op,
    output logic [ALU_SEL_W-1:0]      out_alu_sel,
    output logic [DATA_W-1:0]         out_reg0,
    output logic [DATA_W-1:0]         out_reg1,
    output logic [4:0]                out_waddr,
    output logic                      out_wreg,
    output logic [STALL_CNT_W-1:0]    stall_cnt
);

    dec_t                   dec;
    logic [1:0][4:0]        raddr;
    logic [1:0][DATA_W-1:0] rf_dat;
    logic [1:0][DATA_W-1:0] src_val;
    logic [1:0]             fwd_stall;
    logic [DATA_W-1:0]      imm_val;
    logic [DATA_W-1:0]      op0_nxt;
    logic [DATA_W-1:0]      op1_nxt;
    logic                   wreg_nxt;
    logic                   hazard;
    logic                   adv;
    logic                   accept;
    logic [1:0]             state_q;
    logic [1:0]             state_d;

    id_dec u_dec (
        .inst (in_inst),
        .dec  (dec)
    );

    assign raddr[0]  = dec.rs;
    assign raddr[1]  = dec.rt;
    assign rf_dat[0] = reg0_data;
    assign rf_dat[1] = reg1_data;

    assign reg0_addr = dec.rs;
    assign reg1_addr = dec.rt;
    assign reg0_read = rst_ && in_vld && dec.reg0_read;
    assign reg1_read = rst_ && in_vld && dec.reg1_read;

    // Scan oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        src_val   = '0;
        fwd_stall = '0;
        for (int p = 0; p < 2; p++) begin
            src_val[p] = rf_dat[p];
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_wreg[i] && (fwd_waddr[5*i +: 5] == raddr[p])) begin
                    src_val[p]   = fwd_wdata[DATA_W*i +: DATA_W];
                    fwd_stall[p] = fwd_pend[i];
                end
            end
            if (raddr[p] == 5'd0) begin
                src_val[p]   = '0;
                fwd_stall[p] = 1'b0;
            end
        end
    end

    always_comb begin
        if (dec.sft)
            imm_val = DATA_W'(dec.shamt);
        else if (dec.imme_up)
            imm_val = DATA_W'({dec.imm, 16'h0000});
        else
            imm_val = DATA_W'(dec.imm);
    end

    assign op0_nxt = dec.reg0_read ? src_val[0] : imm_val;
    assign op1_nxt = dec.reg1_read ? src_val[1] : imm_val;

    // Conditional moves decide on the forwarded rt value, not the stale regfile copy.
    always_comb begin
        wreg_nxt = dec.wreg_base;
        if (dec.alu_op == EXE_OP_MOVZ)
            wreg_nxt = (src_val[1] == '0);
        else if (dec.alu_op == EXE_OP_MOVN)
            wreg_nxt = (src_val[1] != '0);
    end

    assign hazard = in_vld && |(fwd_stall & {dec.reg1_read, dec.reg0_read});
    assign adv    = !out_vld || ex_rdy;
    assign in_rdy = rst_ && adv && !hazard && !flush;
    assign accept = in_vld && in_rdy;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_vld     <= 1'b0;
            out_pc      <= '0;
            out_alu_op  <= '0;
            out_alu_sel <= '0;
            out_reg0    <= '0;
            out_reg1    <= '0;
            out_waddr   <= '0;
            out_wreg    <= 1'b0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld     <= 1'b1;
            out_pc      <= in_pc;
            out_alu_op  <= ALU_OP_W'(dec.alu_op);
            out_alu_sel <= ALU_SEL_W'(dec.alu_sel);
            out_reg0    <= op0_nxt;
            out_reg1    <= op1_nxt;
            out_waddr   <= dec.waddr;
            out_wreg    <= wreg_nxt;
        end else if (adv) begin
            out_vld <= 1'b0;
        end
    end

    always_comb begin
        if (flush)
            state_d = ST_RUN;
        else if (out_vld && !ex_rdy)
            state_d = ST_HOLD;
        else if (hazard)
            state_d = ST_HAZ;
        else
            state_d = ST_RUN;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_HAZ) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: stimulus pushes expected ID/EX contents into a queue,
// an independent monitor pops and compares on each out_vld && ex_rdy handshake.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic        in_vld, in_rdy, flush, ex_rdy;
    logic [31:0] in_pc, in_inst;
    logic        reg0_read, reg1_read;
    logic [4:0]  reg0_addr, reg1_addr;
    logic [31:0] reg0_data, reg1_data;
    logic [1:0]  fwd_wreg, fwd_pend;
    logic [9:0]  fwd_waddr;
    logic [63:0] fwd_wdata;
    logic        out_vld, out_wreg;
    logic [31:0] out_pc, out_reg0, out_reg1;
    logic [7:0]  out_alu_op;
    logic [2:0]  out_alu_sel;
    logic [4:0]  out_waddr;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r0;
        logic [31:0] r1;
        logic [4:0]  waddr;
        logic        wreg;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    assign reg0_data = rf[reg0_addr];
    assign reg1_data = rf[reg1_addr];

    id_stage_pipe dut (
        .clk(clk), .rst_(rst_), .in_vld(in_vld), .in_rdy(in_rdy), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush), .reg0_read(reg0_read), .reg0_addr(reg0_addr), .reg0_data(reg0_data),
        .reg1_read(reg1_read), .reg1_addr(reg1_addr), .reg1_data(reg1_data),
        .fwd_wreg(fwd_wreg), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pend(fwd_pend),
        .ex_rdy(ex_rdy), .out_vld(out_vld), .out_pc(out_pc), .out_alu_op(out_alu_op),
        .out_alu_sel(out_alu_sel), .out_reg0(out_reg0), .out_reg1(out_reg1),
        .out_waddr(out_waddr), .out_wreg(out_wreg), .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic [7:0] op,
                        input logic [2:0] sel, input logic [31:0] r0, input logic [31:0] r1,
                        input logic [4:0] waddr, input logic wreg);
        bit   done;
        exp_t e;
        done    = 1'b0;
        e       = '{pc, op, sel, r0, r1, waddr, wreg};
        in_pc   = pc;
        in_inst = inst;
        in_vld  = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_rdy) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout pc=%h: in_rdy stayed 0, required 1", pc);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t a;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ && out_vld && ex_rdy) begin
                a = '{out_pc, out_alu_op, out_alu_sel, out_reg0, out_reg1, out_waddr, out_wreg};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got pc=%h with empty scoreboard", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL txn pc=%h: got op=%h sel=%h r0=%h r1=%h wa=%0d we=%b, required op=%h sel=%h r0=%h r1=%h wa=%0d we=%b",
                                 e.pc, a.op, a.sel, a.r0, a.r1, a.waddr, a.wreg,
                                 e.op, e.sel, e.r0, e.r1, e.waddr, e.wreg);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] add_i;
        rst_      = 1'b0;
        flush     = 1'b0;
        ex_rdy    = 1'b1;
        fwd_wreg  = '0;
        fwd_pend  = '0;
        fwd_waddr = '0;
        fwd_wdata = '0;
        for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
        rf[0] = 32'hDEADBEEF;
        rf[7] = 32'h1;
        in_pc   = 32'h0;
        in_inst = enc_i(INS_OP_GRP_ORI, 5'd0, 5'd1, 16'h1234);
        in_vld  = 1'b1;

        #12;
        chk("rst_ctl", 64'({out_vld, out_wreg, out_waddr, out_alu_op, out_alu_sel}), 64'h0);
        chk("rst_pc", 64'(out_pc), 64'h0);
        chk("rst_ops", {out_reg0, out_reg1}, 64'h0);
        chk("rst_cnt", 64'(stall_cnt), 64'h0);
        chk("rst_rdy", 64'({in_rdy, reg0_read, reg1_read}), 64'h0);
        in_vld = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        cyc(1);

        // ori with rs=$0: $0 reads as zero even though the regfile model holds junk.
        in_vld = 1'b1;
        #1;
        chk("rf_ports_ori", 64'({reg0_read, reg1_read, reg0_addr, reg1_addr}),
            64'({1'b1, 1'b0, 5'd0, 5'd1}));
        send(32'h100, enc_i(INS_OP_GRP_ORI, 5'd0, 5'd1, 16'h1234), EXE_OP_OR, EXE_RES_LOGIC,
             32'h0, 32'h1234, 5'd1, 1'b1);

        fwd_wreg  = 2'b11;
        fwd_waddr = {5'd1, 5'd1};
        fwd_wdata = {32'd9, 32'd5};
        send(32'h104, enc_r(5'd1, 5'd2, 5'd3, 5'd0, INS_FUNC_GRP_OR), EXE_OP_OR, EXE_RES_LOGIC,
             32'd5, 32'h22, 5'd3, 1'b1);
        fwd_wreg  = 2'b10;
        fwd_waddr = {5'd2, 5'd1};
        send(32'h108, enc_r(5'd1, 5'd2, 5'd3, 5'd0, INS_FUNC_GRP_AND), EXE_OP_AND, EXE_RES_LOGIC,
             32'h11, 32'd9, 5'd3, 1'b1);
        fwd_wreg  = 2'b01;
        fwd_waddr = {5'd0, 5'd0};
        fwd_wdata = {32'd0, 32'h77};
        send(32'h10C, enc_r(5'd0, 5'd2, 5'd4, 5'd0, INS_FUNC_GRP_OR), EXE_OP_OR, EXE_RES_LOGIC,
             32'h0, 32'h22, 5'd4, 1'b1);
        fwd_wreg = 2'b00;
        send(32'h110, enc_r(5'd0, 5'd3, 5'd2, 5'd4, INS_FUNC_GRP_SLL), EXE_OP_SLL, EXE_RES_SHIFT,
             32'd4, 32'h33, 5'd2, 1'b1);
        send(32'h114, enc_i(INS_OP_GRP_LUI, 5'd0, 5'd7, 16'hABCD), EXE_OP_OR, EXE_RES_LOGIC,
             32'h0, 32'hABCD0000, 5'd7, 1'b1);
        send(32'h118, 32'hFC000000, EXE_OP_NOP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        cyc(2);

        // Load-use: $4 pending in EX for three cycles.
        add_i     = enc_r(5'd4, 5'd5, 5'd8, 5'd0, INS_FUNC_GRP_ADD);
        fwd_wreg  = 2'b01;
        fwd_waddr = {5'd0, 5'd4};
        fwd_pend  = 2'b01;
        fwd_wdata = '0;
        in_pc     = 32'h120;
        in_inst   = add_i;
        in_vld    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("haz_in_rdy", 64'(in_rdy), 64'h0);
            chk("haz_bubble", 64'(out_vld), 64'h0);
            @(posedge clk);
            #1;
        end
        fwd_pend  = 2'b00;
        fwd_wdata = {32'd0, 32'h40};
        send(32'h120, add_i, EXE_OP_ADD, EXE_RES_ARITH, 32'h40, 32'h55, 5'd8, 1'b1);
        fwd_wreg = 2'b00;
        cyc(2);
        chk("haz_stall_cnt", 64'(stall_cnt), 64'd3);

        // EX back-pressure for two cycles with the next instruction waiting.
        ex_rdy = 1'b0;
        send(32'h130, enc_r(5'd1, 5'd2, 5'd9, 5'd0, INS_FUNC_GRP_XOR), EXE_OP_XOR, EXE_RES_LOGIC,
             32'h11, 32'h22, 5'd9, 1'b1);
        in_pc   = 32'h134;
        in_inst = enc_r(5'd1, 5'd2, 5'd10, 5'd0, INS_FUNC_GRP_NOR);
        in_vld  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_in_rdy", 64'(in_rdy), 64'h0);
            chk("hold_vld", 64'(out_vld), 64'h1);
            chk("hold_pc", 64'(out_pc), 64'h130);
            chk("hold_reg0", 64'(out_reg0), 64'h11);
            @(posedge clk);
            #1;
        end
        ex_rdy = 1'b1;
        send(32'h134, enc_r(5'd1, 5'd2, 5'd10, 5'd0, INS_FUNC_GRP_NOR), EXE_OP_NOR, EXE_RES_LOGIC,
             32'h11, 32'h22, 5'd10, 1'b1);
        cyc(1);
        chk("hold_no_count", 64'(stall_cnt), 64'd3);

        // movz/movn decide on forwarded rt, while regfile $7 holds 1.
        fwd_wreg  = 2'b01;
        fwd_waddr = {5'd0, 5'd7};
        fwd_wdata = {32'd0, 32'd0};
        send(32'h140, enc_r(5'd6, 5'd7, 5'd5, 5'd0, INS_FUNC_GRP_MOVZ), EXE_OP_MOVZ, EXE_RES_MOVE,
             32'h66, 32'h0, 5'd5, 1'b1);
        fwd_wdata = {32'd0, 32'd3};
        send(32'h144, enc_r(5'd6, 5'd7, 5'd5, 5'd0, INS_FUNC_GRP_MOVZ), EXE_OP_MOVZ, EXE_RES_MOVE,
             32'h66, 32'd3, 5'd5, 1'b0);
        send(32'h148, enc_r(5'd6, 5'd7, 5'd5, 5'd0, INS_FUNC_GRP_MOVN), EXE_OP_MOVN, EXE_RES_MOVE,
             32'h66, 32'd3, 5'd5, 1'b1);
        fwd_wreg = 2'b00;

        // Flush while a new instruction is offered.
        send(32'h150, enc_i(INS_OP_GRP_ORI, 5'd0, 5'd1, 16'h0001), EXE_OP_OR, EXE_RES_LOGIC,
             32'h0, 32'h1, 5'd1, 1'b1);
        flush   = 1'b1;
        in_pc   = 32'h154;
        in_inst = enc_i(INS_OP_GRP_XORI, 5'd1, 5'd2, 16'h000F);
        in_vld  = 1'b1;
        @(negedge clk);
        chk("flush_in_rdy", 64'(in_rdy), 64'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_kill", 64'(out_vld), 64'h0);
        send(32'h154, enc_i(INS_OP_GRP_XORI, 5'd1, 5'd2, 16'h000F), EXE_OP_XOR, EXE_RES_LOGIC,
             32'h11, 32'hF, 5'd2, 1'b1);
        cyc(1);

        // Reset asserted in the middle of a load-use stall.
        fwd_wreg  = 2'b01;
        fwd_waddr = {5'd0, 5'd4};
        fwd_pend  = 2'b01;
        in_pc     = 32'h160;
        in_inst   = add_i;
        in_vld    = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("pre_rst_cnt", 64'(stall_cnt), 64'd4);
        rst_ = 1'b0;
        #1;
        chk("mid_rst_ctl", 64'({out_vld, out_wreg, out_waddr, out_alu_op, out_alu_sel}), 64'h0);
        chk("mid_rst_pc", 64'(out_pc), 64'h0);
        chk("mid_rst_ops", {out_reg0, out_reg1}, 64'h0);
        chk("mid_rst_cnt", 64'(stall_cnt), 64'h0);
        chk("mid_rst_rdy", 64'({in_rdy, reg0_read, reg1_read}), 64'h0);
        in_vld   = 1'b0;
        fwd_pend = 2'b00;
        fwd_wreg = 2'b00;
        @(negedge clk);
        rst_ = 1'b1;
        cyc(2);
        chk("post_rst_rdy", 64'(in_rdy), 64'h1);
        chk("post_rst_cnt", 64'(stall_cnt), 64'h0);

        cyc(2);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
